// File: rtl/bcd_multi_counter.sv
// bcd_multi_counter: prescaled N-digit BCD up/down counter with load, clear, single-step and wrap/saturate limit.
module bcd_multi_counter #(
  parameter int CLK_DIV = 50000000,
  parameter int NDIG = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset_n,
  input  logic              run,
  input  logic              up,
  input  logic              step,
  input  logic              clr,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic              tick,
  output logic [4*NDIG-1:0] bcd,
  output logic              tc,
  output logic              at_limit
);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0] pre;
  logic [NDIG:0] c;
  logic [4*NDIG-1:0] nxt, ld;
  logic ev;
  assign tick = run && pre == PW'(CLK_DIV - 1);
  assign ev = tick || (step && !run);
  assign c[0] = 1'b1;
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic [3:0] d, v;
    assign d = bcd[4*g +: 4];
    assign v = load_val[4*g +: 4];
    assign c[g+1] = c[g] && d == (up ? 4'd9 : 4'd0);
    assign nxt[4*g +: 4] = !c[g] ? d : up ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
    assign ld[4*g +: 4] = v > 4'd9 ? 4'd0 : v;
  end
  assign at_limit = c[NDIG];
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      bcd <= '0;
      tc <= 1'b0;
    end else begin
      pre <= (clr || load || tick) ? '0 : run ? pre + 1'b1 : pre;
      bcd <= clr ? '0 : load ? ld : (ev && !(at_limit && !WRAP)) ? nxt : bcd;
      tc <= !clr && !load && ev && at_limit;
    end
  end
endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb_bcd_multi_counter: directed vectors and sequences for a 2-digit, divide-by-4 counter in wrap and saturate builds.
module tb_bcd_multi_counter;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic run = 1'b0, up = 1'b1, step = 1'b0, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;
  logic tick, tc, at_limit, tick_s, tc_s, lim_s;
  logic [7:0] bcd, bcd_s;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  bcd_multi_counter #(.CLK_DIV(4), .NDIG(2), .WRAP(1'b1)) dut (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .run(run), .up(up), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .tick(tick), .bcd(bcd), .tc(tc), .at_limit(at_limit)
  );
  bcd_multi_counter #(.CLK_DIV(4), .NDIG(2), .WRAP(1'b0)) dus (
    .MAX10_CLK1_50(clk), .reset_n(reset_n), .run(run), .up(up), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .tick(tick_s), .bcd(bcd_s), .tc(tc_s), .at_limit(lim_s)
  );
  typedef struct {
    logic r, u, s, c, l;
    logic [7:0] lv, eb;
    logic etc, etk, elim;
  } vec_t;
  vec_t tv[35];
  function automatic vec_t mk(input logic r, u, s, c, l, input logic [7:0] lv, eb, input logic etc, etk, elim);
    mk.r = r; mk.u = u; mk.s = s; mk.c = c; mk.l = l; mk.lv = lv; mk.eb = eb;
    mk.etc = etc; mk.etk = etk; mk.elim = elim;
  endfunction
  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  task automatic drive(input logic r, u, s, c, l, input logic [7:0] lv);
    @(negedge clk);
    run = r; up = u; step = s; clr = c; load = l; load_val = lv;
    #1;
  endtask
  initial begin
    tv[0]  = mk(0,1,0,0,1,8'h05, 8'h00,0,0,0);
    tv[1]  = mk(0,1,1,0,0,8'h00, 8'h05,0,0,0);
    tv[2]  = mk(0,1,1,0,0,8'h00, 8'h06,0,0,0);
    tv[3]  = mk(0,1,1,0,0,8'h00, 8'h07,0,0,0);
    tv[4]  = mk(0,1,0,0,0,8'h00, 8'h08,0,0,0);
    tv[5]  = mk(0,1,0,0,0,8'h00, 8'h08,0,0,0);
    tv[6]  = mk(1,1,1,0,0,8'h00, 8'h08,0,0,0);
    tv[7]  = mk(1,1,1,0,0,8'h00, 8'h08,0,0,0);
    tv[8]  = mk(1,1,0,0,0,8'h00, 8'h08,0,0,0);
    tv[9]  = mk(1,1,1,0,0,8'h00, 8'h08,0,1,0);
    tv[10] = mk(1,1,0,0,0,8'h00, 8'h09,0,0,0);
    tv[11] = mk(1,1,0,0,0,8'h00, 8'h09,0,0,0);
    tv[12] = mk(0,1,0,0,0,8'h00, 8'h09,0,0,0);
    tv[13] = mk(0,1,0,0,0,8'h00, 8'h09,0,0,0);
    tv[14] = mk(1,1,0,0,0,8'h00, 8'h09,0,0,0);
    tv[15] = mk(1,1,0,0,0,8'h00, 8'h09,0,1,0);
    tv[16] = mk(0,1,0,0,0,8'h00, 8'h10,0,0,0);
    tv[17] = mk(0,1,0,0,1,8'h4A, 8'h10,0,0,0);
    tv[18] = mk(1,1,0,0,0,8'h00, 8'h40,0,0,0);
    tv[19] = mk(1,1,0,0,0,8'h00, 8'h40,0,0,0);
    tv[20] = mk(1,1,0,0,0,8'h00, 8'h40,0,0,0);
    tv[21] = mk(1,1,0,1,1,8'h55, 8'h40,0,1,0);
    tv[22] = mk(1,1,0,0,0,8'h00, 8'h00,0,0,0);
    tv[23] = mk(1,1,0,0,0,8'h00, 8'h00,0,0,0);
    tv[24] = mk(1,1,0,0,0,8'h00, 8'h00,0,0,0);
    tv[25] = mk(1,1,0,0,0,8'h00, 8'h00,0,1,0);
    tv[26] = mk(0,1,0,0,0,8'h00, 8'h01,0,0,0);
    tv[27] = mk(0,1,0,0,1,8'hC7, 8'h01,0,0,0);
    tv[28] = mk(0,0,1,0,0,8'h00, 8'h07,0,0,0);
    tv[29] = mk(0,0,0,1,0,8'h00, 8'h06,0,0,0);
    tv[30] = mk(0,0,0,0,0,8'h00, 8'h00,0,0,1);
    tv[31] = mk(0,1,0,0,0,8'h00, 8'h00,0,0,0);
    tv[32] = mk(0,0,1,0,0,8'h00, 8'h00,0,0,1);
    tv[33] = mk(0,0,0,0,0,8'h00, 8'h99,1,0,0);
    tv[34] = mk(0,0,0,0,0,8'h00, 8'h99,0,0,0);
    #1 reset_n = 1'b0;
    #2;
    check("rst_bcd", bcd, 8'h00);
    check("rst_tc", {7'd0, tc}, 8'd0);
    check("rst_tick", {7'd0, tick}, 8'd0);
    check("rst_lim_up", {7'd0, at_limit}, 8'd0);
    up = 1'b0;
    #1 check("rst_lim_dn", {7'd0, at_limit}, 8'd1);
    up = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    // up count through carries and the 99 -> 00 wrap
    drive(1,1,0,1,0,8'h00);
    for (int c = 0; c < 404; c++) begin
      drive(1,1,0,0,0,8'h00);
      check("up_tick", {7'd0, tick}, {7'd0, c % 4 == 3});
      check("up_bcd", bcd, to_bcd((c / 4) % 100));
      check("up_tc", {7'd0, tc}, {7'd0, c == 400});
      check("up_lim", {7'd0, at_limit}, {7'd0, (c / 4) % 100 == 99});
      if (c == 400) begin
        check("sat_up_bcd", bcd_s, 8'h99);
        check("sat_up_tc", {7'd0, tc_s}, 8'd1);
      end
    end
    // down count from 00: wrap to 99 vs saturate at 00
    drive(1,0,0,1,0,8'h00);
    for (int c = 0; c < 13; c++) begin
      drive(1,0,0,0,0,8'h00);
      check("dn_bcd", bcd, to_bcd((100 - c / 4) % 100));
      check("dn_tc", {7'd0, tc}, {7'd0, c == 4});
      check("dn_lim", {7'd0, at_limit}, {7'd0, c < 4});
      check("dn_sat_bcd", bcd_s, 8'h00);
      check("dn_sat_tc", {7'd0, tc_s}, {7'd0, c == 4 || c == 8 || c == 12});
    end
    drive(1,0,0,0,1,8'h10);
    for (int c = 0; c < 5; c++) begin
      drive(1,0,0,0,0,8'h00);
      check("borrow_bcd", bcd, c < 4 ? 8'h10 : 8'h09);
    end
    // saturate build: hold at 99, repeat tc, direction flip releases the limit
    drive(1,1,0,0,1,8'h98);
    for (int c = 0; c < 13; c++) begin
      drive(1, c < 10, 0,0,0,8'h00);
      check("sat_bcd", bcd_s, c < 4 ? 8'h98 : c < 12 ? 8'h99 : 8'h98);
      check("sat_tc", {7'd0, tc_s}, {7'd0, c == 8});
      check("sat_lim", {7'd0, lim_s}, {7'd0, c >= 4 && c < 10});
      check("sat_tick", {7'd0, tick_s}, {7'd0, c % 4 == 3});
      if (c == 8) begin
        check("wrap_bcd", bcd, 8'h00);
        check("wrap_tc", {7'd0, tc}, 8'd1);
      end
      if (c == 12) begin
        check("wrap_dn_bcd", bcd, 8'h99);
        check("wrap_dn_tc", {7'd0, tc}, 8'd1);
      end
    end
    drive(0,1,0,1,0,8'h00);
    for (int i = 0; i < 35; i++) begin
      drive(tv[i].r, tv[i].u, tv[i].s, tv[i].c, tv[i].l, tv[i].lv);
      check($sformatf("vec%0d_bcd", i), bcd, tv[i].eb);
      check($sformatf("vec%0d_tc", i), {7'd0, tc}, {7'd0, tv[i].etc});
      check($sformatf("vec%0d_tick", i), {7'd0, tick}, {7'd0, tv[i].etk});
      check($sformatf("vec%0d_lim", i), {7'd0, at_limit}, {7'd0, tv[i].elim});
    end
    // asynchronous reset mid-period
    drive(1,1,0,0,1,8'h37);
    repeat (3) drive(1,1,0,0,0,8'h00);
    check("pre_rst_bcd", bcd, 8'h37);
    reset_n = 1'b0;
    #1;
    check("arst_bcd", bcd, 8'h00);
    check("arst_bcd_s", bcd_s, 8'h00);
    check("arst_tc", {7'd0, tc}, 8'd0);
    check("arst_tick", {7'd0, tick}, 8'd0);
    repeat (2) @(posedge clk);
    #1 check("arst_hold", bcd, 8'h00);
    @(negedge clk) reset_n = 1'b1;
    #1 check("rel_tick0", {7'd0, tick}, 8'd0);
    for (int c = 1; c < 5; c++) begin
      drive(1,1,0,0,0,8'h00);
      check("rel_tick", {7'd0, tick}, {7'd0, c == 3});
      check("rel_bcd", bcd, c < 4 ? 8'h00 : 8'h01);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bcd_multi_counter.md
Name: bcd_multi_counter

Overview:
Parametrised multi-digit BCD counter driven by an internal clock prescaler. It replaces the single-digit seconds counter with a run/stop, up/down, loadable, clearable N-digit counter, plus single-step and wrap/saturate modes. Packed BCD output feeds per-digit SEG7_LUT instances on HEX0..HEX5 at top level. Carry/limit flags allow cascading or alarms.

Parameters:
CLK_DIV, 50000000, clock cycles per count event (>=2); default gives 1 Hz from 50 MHz
NDIG, 4, number of BCD digits (1..6)
WRAP, 1, 1 = wrap at limit, 0 = saturate at limit

Ports:
MAX10_CLK1_50  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = prescaler advances and count events occur on ticks
up  input  1  direction; 1 = increment, 0 = decrement
step  input  1  one-cycle pulse; one count event when run=0, ignored when run=1
clr  input  1  synchronous clear
load  input  1  synchronous load of load_val
load_val  input  4*NDIG  packed BCD load value, digit 0 in [3:0]
tick  output  1  prescaler terminal pulse
bcd  output  4*NDIG  packed BCD count, digit 0 in [3:0]
tc  output  1  registered one-cycle pulse on wrap (or limit hit when WRAP=0)
at_limit  output  1  level: count is all-9s while up=1, or all-0s while up=0

Behaviour:
- Reset (reset_n=0, async): prescaler=0, bcd=0, tc=0. tick=0 and at_limit=(up==0) follow combinationally.
- Prescaler: width clog2(CLK_DIV). With run=1 it counts 0..CLK_DIV-1 and returns to 0. With run=0 it holds.
- tick = run & (prescaler==CLK_DIV-1). It is combinational and lasts exactly one cycle every CLK_DIV cycles.
- Count event ev = tick | (step & ~run).
- Priority per cycle: clr > load > ev.
  - clr: bcd<=0, prescaler<=0.
  - load: bcd<=load_val, prescaler<=0. Any loaded digit >9 is stored as 0.
- Latency: bcd changes on the clock edge ending the cycle in which ev is high. That is one edge after tick is sampled high.
- Up count: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit, rippling through all digits in the same cycle.
- Down count: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Limit crossing, up from all-9s:
  - WRAP=1: bcd<=0, tc=1 for one cycle.
  - WRAP=0: bcd holds all-9s, tc=1 on the first ev attempting to pass the limit and on every subsequent ev.
- Limit crossing, down from all-0s: symmetric. WRAP=1 gives all-9s with a tc pulse; WRAP=0 holds at 0 with a tc pulse.
- tc is registered and coincides with the updated bcd value. It is 0 in any cycle without a limit-crossing ev. clr and load never raise tc.
- Changing up between events takes effect at the next ev. No glitch on bcd.
- clr/load in the same cycle as tick: the tick's count is discarded and the prescaler restarts at 0.
- run deasserted mid-period: the prescaler freezes and resumes from the same value.
- Asserting reset_n mid-operation returns everything to reset values immediately.
- bcd digits are always in 0..9. No non-BCD state is reachable.

Test Plan:
1. CLK_DIV=4, NDIG=2, run=1, up=1 from reset -> tick every 4th cycle; bcd 00,01,..,09,10 (carry on tick 10),..,99; tick 100 gives 00 with tc=1 for 1 cycle.
2. Same setup, up=0 from 00 -> first tick gives 99 with tc=1; next ticks give 98,97; 10 -> 09 shows borrow.
3. WRAP=0, load 98, up=1, run=1 -> 99 with at_limit=1; next tick holds 99 with tc=1; flip up=0 -> at_limit=0; next tick gives 98.
4. run=0, three step pulses from 05 -> 06,07,08, prescaler stays frozen (no tick). With run=1, step is ignored: count advances only on ticks.
5. load=1 with load_val=0x4A and clr=0 -> bcd=40 (digit >9 forced to 0). Then clr and load together in a tick cycle -> bcd=00, no tc, next tick after 4 cycles.
6. reset_n pulsed low mid-period with bcd=37, prescaler=2 -> bcd=00, tc=0 asynchronously; after release, first tick occurs 4 cycles later.
